// File: rtl/mul_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
// State encoding, digit/partial widths and per-WIDTH derived counts.
package mul_seq_pkg;

  localparam int DIG_W  = 2;
  localparam int PART_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // digits per operand
  function automatic int ndig(input int w);
    return w / DIG_W;
  endfunction

  // RUN cycles per operation
  function automatic int nstep(input int w);
    return ndig(w) * ndig(w);
  endfunction

  // digit counter width, never zero
  function automatic int cnt_w(input int w);
    return (ndig(w) > 1) ? $clog2(ndig(w)) : 1;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul2x2_core.sv
// Combinational 2x2 -> 4-bit unsigned multiplier cell.
// Ports: x[1:0], y[1:0] digits in; p[3:0] product out.
module mul2x2_core
  import mul_seq_pkg::*;
(
  input  logic [DIG_W-1:0]  x,
  input  logic [DIG_W-1:0]  y,
  output logic [PART_W-1:0] p
);

  logic [DIG_W-1:0] pp0;
  logic [DIG_W-1:0] pp1;

  assign pp0 = y[0] ? x : '0;
  assign pp1 = y[1] ? x : '0;
  assign p   = {2'b00, pp0} + {1'b0, pp1, 1'b0};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier over one shared 2x2 cell.
// Ports: clk, rst_n, start/a_in/b_in in; ready, busy, done, product out.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ND = ndig(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW) + 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CW-1:0]     i_q;
  logic [CW-1:0]     j_q;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     prod_q;
  logic              done_q;

  logic [DIG_W-1:0]  ad;
  logic [DIG_W-1:0]  bd;
  logic [PART_W-1:0] part;
  logic [SW-1:0]     sh;
  logic [PW-1:0]     term;
  logic [PW-1:0]     sum;
  logic              j_wrap;
  logic              last;

  assign ad = a_q[DIG_W*i_q +: DIG_W];
  assign bd = b_q[DIG_W*j_q +: DIG_W];

  mul2x2_core u_cell (
    .x (ad),
    .y (bd),
    .p (part)
  );

  // digit weight is 4^(i+j), i.e. a left shift by 2*(i+j)
  assign sh     = SW'(i_q) + SW'(j_q);
  assign term   = PW'(part) << {sh, 1'b0};
  assign sum    = acc + term;
  assign j_wrap = (j_q == LAST);
  assign last   = j_wrap && (i_q == LAST);

  assign ready   = (state == IDLE);
  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign product = prod_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      acc    <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            state <= RUN;
          end
        end
        (state == RUN): begin
          acc <= sum;
          if (j_wrap) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
          if (last) begin
            i_q    <= '0;
            prod_q <= sum;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        (state == DONE): begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl at WIDTH 2, 4 and 8.
// Vector table, corner sequences and held-start sweeps vs a*b model.
module tb_mul_seq_ctrl;

  logic clk;
  logic rst_n;

  logic       st2, rdy2, bsy2, dn2;
  logic [1:0] a2, b2;
  logic [3:0] p2;

  logic       st4, rdy4, bsy4, dn4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        st8, rdy8, bsy8, dn8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_chk;
  int n_fail;
  int cyc;

  mul_seq_ctrl #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a_in(a2), .b_in(b2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .product(p2)
  );

  mul_seq_ctrl #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a_in(a4), .b_in(b4),
    .ready(rdy4), .busy(bsy4), .done(dn4), .product(p4)
  );

  mul_seq_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a_in(a8), .b_in(b8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .product(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act,
                              input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // scoreboards for the held-start sweeps: expected product and
  // accept cycle per operation, plus spacing between accepts
  bit sb2, sb4, sb8;
  int q2[$], q4[$], q8[$];
  int c2[$], c4[$], c8[$];
  int last2, last4, last8;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && sb2 && st2 && rdy2) begin
      if (last2 >= 0) chk("w2_gap", cyc - last2, 1 + 2);
      last2 = cyc;
      q2.push_back(int'(a2) * int'(b2));
      c2.push_back(cyc);
    end
    if (rst_n && sb4 && st4 && rdy4) begin
      if (last4 >= 0) chk("w4_gap", cyc - last4, 4 + 2);
      last4 = cyc;
      q4.push_back(int'(a4) * int'(b4));
      c4.push_back(cyc);
    end
    if (rst_n && sb8 && st8 && rdy8) begin
      if (last8 >= 0) chk("w8_gap", cyc - last8, 16 + 2);
      last8 = cyc;
      q8.push_back(int'(a8) * int'(b8));
      c8.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (sb2 && dn2) begin
      if (q2.size() == 0) chk("w2_spurious_done", 1, 0);
      else begin
        chk("w2_product", p2, q2.pop_front());
        chk("w2_latency", cyc - c2.pop_front(), 1);
      end
    end
    if (sb4 && dn4) begin
      if (q4.size() == 0) chk("w4_spurious_done", 1, 0);
      else begin
        chk("w4_product", p4, q4.pop_front());
        chk("w4_latency", cyc - c4.pop_front(), 4);
      end
    end
    if (sb8 && dn8) begin
      if (q8.size() == 0) chk("w8_spurious_done", 1, 0);
      else begin
        chk("w8_product", p8, q8.pop_front());
        chk("w8_latency", cyc - c8.pop_front(), 16);
      end
    end
  end

  // one WIDTH=4 operation with cycle-accurate checks; optionally
  // pokes a second start mid-RUN which must be ignored
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input int exp, input bit drop);
    int n;
    int prev;
    @(negedge clk);
    chk("op_ready_before", rdy4, 1);
    prev = int'(p4);
    a4 = a; b4 = b; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    n = 0;
    while (!dn4 && n < 20) begin
      chk("op_busy_run", bsy4, 1);
      chk("op_product_stable", p4, prev);
      if (drop && n == 1) begin
        a4 = 4'd3; b4 = 4'd3; st4 = 1'b1;
      end
      if (drop && n == 2) st4 = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("op_latency", n, 4);
    chk("op_product", p4, exp);
    chk("op_busy_done", bsy4, 1);
    chk("op_ready_done", rdy4, 0);
    @(negedge clk);
    chk("op_done_pulse", dn4, 0);
    chk("op_ready_after", rdy4, 1);
    chk("op_product_hold", p4, exp);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int extra;
    int k;
    logic [3:0] ra, rb;
    n_chk = 0; n_fail = 0; cyc = 0;
    sb2 = 0; sb4 = 0; sb8 = 0;
    last2 = -1; last4 = -1; last8 = -1;
    st2 = 0; st4 = 0; st8 = 0;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    rst_n = 1'b0;

    vecs.push_back('{4'd15, 4'd15, 225});
    vecs.push_back('{4'd10, 4'd5,  50});
    vecs.push_back('{4'd0,  4'd13, 0});
    vecs.push_back('{4'd13, 4'd0,  0});
    vecs.push_back('{4'd1,  4'd1,  1});
    vecs.push_back('{4'd15, 4'd1,  15});
    vecs.push_back('{4'd7,  4'd9,  63});
    vecs.push_back('{4'd2,  4'd3,  6});
    vecs.push_back('{4'd12, 4'd11, 132});

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy4, 1);
    chk("rst_busy", bsy4, 0);
    chk("rst_done", dn4, 0);
    chk("rst_product", p4, 0);
    chk("rst_product_w8", p8, 0);
    rst_n = 1'b1;

    foreach (vecs[v]) do_op(vecs[v].a, vecs[v].b, vecs[v].exp, 1'b0);

    // start during RUN is dropped, no second done
    do_op(4'd10, 4'd5, 50, 1'b1);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (dn4) extra++;
    end
    chk("drop_no_second_done", extra, 0);
    chk("drop_product_kept", p4, 50);
    chk("drop_ready", rdy4, 1);

    // reset in the middle of RUN
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", bsy4, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", rdy4, 1);
    chk("abort_busy", bsy4, 0);
    chk("abort_product", p4, 0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (dn4) extra++;
    end
    chk("abort_no_done", extra, 0);
    do_op(4'd2, 4'd3, 6, 1'b0);

    // random single operations
    repeat (20) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_op(ra, rb, int'(ra) * int'(rb), 1'b0);
    end

    // held-start exhaustive sweep, WIDTH=4
    sb4 = 1; st4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        k = 0;
        while (!rdy4 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) chk("w4_ready_timeout", k, 0);
        a4 = 4'(a); b4 = 4'(b);
        @(posedge clk);
      end
    end
    @(negedge clk);
    st4 = 1'b0;
    k = 0;
    while (q4.size() != 0 && k < 50) begin @(negedge clk); k++; end
    chk("w4_drain", q4.size(), 0);
    sb4 = 0;

    // held-start exhaustive sweep, WIDTH=2
    sb2 = 1; st2 = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        k = 0;
        while (!rdy2 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) chk("w2_ready_timeout", k, 0);
        a2 = 2'(a); b2 = 2'(b);
        @(posedge clk);
      end
    end
    @(negedge clk);
    st2 = 1'b0;
    k = 0;
    while (q2.size() != 0 && k < 50) begin @(negedge clk); k++; end
    chk("w2_drain", q2.size(), 0);
    sb2 = 0;

    // held-start random sweep, WIDTH=8, including the extremes
    sb8 = 1; st8 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      k = 0;
      while (!rdy8 && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) chk("w8_ready_timeout", k, 0);
      if (n == 0) begin
        a8 = 8'hFF; b8 = 8'hFF;
      end else if (n == 1) begin
        a8 = 8'h00; b8 = 8'hA5;
      end else begin
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
      end
      @(posedge clk);
    end
    @(negedge clk);
    st8 = 1'b0;
    k = 0;
    while (q8.size() != 0 && k < 50) begin @(negedge clk); k++; end
    chk("w8_drain", q8.size(), 0);
    sb8 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
